// File: rtl/pc_pkg.sv
// Shared pc_next_unit definitions:
// next-PC select encodings and default vectors.
package pc_pkg;

  localparam int PCSEL_W = 3;

  localparam logic [PCSEL_W-1:0] PCSEL_SEQ    = 3'd0;
  localparam logic [PCSEL_W-1:0] PCSEL_BRANCH = 3'd1;
  localparam logic [PCSEL_W-1:0] PCSEL_JUMP   = 3'd2;
  localparam logic [PCSEL_W-1:0] PCSEL_JREG   = 3'd3;
  localparam logic [PCSEL_W-1:0] PCSEL_RET    = 3'd4;
  localparam logic [PCSEL_W-1:0] PCSEL_EXC    = 3'd5;

  localparam logic [31:0] DEF_RESET_VECTOR = 32'h0000_0000;
  localparam logic [31:0] DEF_EXC_VECTOR   = 32'h8000_0180;

endpackage

// File: rtl/pc_next_unit_if.sv
// Control-unit <-> PC unit bundle.
// master: control side; slave: pc_next_unit.
interface pc_next_unit_if #(
  parameter int WIDTH = 32
);
  import pc_pkg::*;

  logic               stall;
  logic [PCSEL_W-1:0] pcSel;
  logic               isCall;
  logic [WIDTH-1:0]   bResult;
  logic [WIDTH-1:0]   jTarget;
  logic [WIDTH-1:0]   jrTarget;
  logic [WIDTH-1:0]   pc;
  logic [WIDTH-1:0]   pcPlus;
  logic               rasEmpty;
  logic               rasOverflow;
  logic               rasUnderflow;

  modport master (
    output stall, pcSel, isCall,
    output bResult, jTarget, jrTarget,
    input  pc, pcPlus,
    input  rasEmpty, rasOverflow,
    input  rasUnderflow
  );

  modport slave (
    input  stall, pcSel, isCall,
    input  bResult, jTarget, jrTarget,
    output pc, pcPlus,
    output rasEmpty, rasOverflow,
    output rasUnderflow
  );

endinterface

// File: rtl/ras_stack.sv
// Circular return-address stack; push wins
// over oldest entry when full (sticky overflow).
module ras_stack #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic [WIDTH-1:0] i_wdata,
  output logic [WIDTH-1:0] o_top_data,
  output logic             o_empty,
  output logic             o_full,
  output logic             o_overflow
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_top;
  logic [CW-1:0]    r_cnt;
  logic             r_ovf;
  logic [PW-1:0]    w_top_inc;
  logic [PW-1:0]    w_top_dec;

  assign w_top_inc = r_top + PW'(1);
  assign w_top_dec = r_top - PW'(1);
  assign o_empty   = (r_cnt == '0);
  assign o_full    = (r_cnt == CW'(DEPTH));
  assign o_top_data = r_mem[r_top];
  assign o_overflow = r_ovf;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_top <= '0;
      r_cnt <= '0;
      r_ovf <= 1'b0;
    end else if (i_push) begin
      r_mem[w_top_inc] <= i_wdata;
      r_top <= w_top_inc;
      if (o_full) r_ovf <= 1'b1;
      else        r_cnt <= r_cnt + CW'(1);
    end else if (i_pop && !o_empty) begin
      r_top <= w_top_dec;
      r_cnt <= r_cnt - CW'(1);
    end
  end

endmodule

// File: rtl/pc_next_unit.sv
// PC register, six-source next-PC mux and RAS.
// Ports: clk, rst, bus (pc_next_unit_if.slave).
module pc_next_unit
  import pc_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int INC   = 4,
  parameter logic [WIDTH-1:0] RESET_VECTOR =
    WIDTH'(DEF_RESET_VECTOR),
  parameter logic [WIDTH-1:0] EXC_VECTOR =
    WIDTH'(DEF_EXC_VECTOR),
  parameter int RAS_DEPTH = 4
) (
  input  logic           clk,
  input  logic           rst,
  pc_next_unit_if.slave  bus
);

  logic [WIDTH-1:0] r_pc;
  logic             r_unf;
  logic [WIDTH-1:0] w_plus;
  logic [WIDTH-1:0] w_next;
  logic [WIDTH-1:0] w_top;
  logic w_br, w_jmp, w_jr, w_ret, w_exc;
  logic w_push, w_pop;
  logic w_empty, w_full, w_ovf;

  assign w_br  = (bus.pcSel == PCSEL_BRANCH);
  assign w_jmp = (bus.pcSel == PCSEL_JUMP);
  assign w_jr  = (bus.pcSel == PCSEL_JREG);
  assign w_ret = (bus.pcSel == PCSEL_RET);
  assign w_exc = (bus.pcSel == PCSEL_EXC);

  assign w_plus = r_pc + WIDTH'(INC);

  // Calls only ride on control transfers.
  assign w_push = !bus.stall && bus.isCall
                && (w_br || w_jmp || w_jr);
  assign w_pop  = !bus.stall && w_ret && !w_empty;

  always_comb begin
    w_next = w_plus;
    unique case (1'b1)
      w_br:  w_next = bus.bResult;
      w_jmp: w_next = bus.jTarget;
      w_jr:  w_next = bus.jrTarget;
      w_ret: w_next = w_empty ? bus.jrTarget
                              : w_top;
      w_exc: w_next = EXC_VECTOR;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc  <= RESET_VECTOR;
      r_unf <= 1'b0;
    end else begin
      if (!bus.stall) r_pc <= w_next;
      r_unf <= !bus.stall && w_ret && w_empty;
    end
  end

  ras_stack #(
    .WIDTH (WIDTH),
    .DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk        (clk),
    .rst        (rst),
    .i_push     (w_push),
    .i_pop      (w_pop),
    .i_wdata    (w_plus),
    .o_top_data (w_top),
    .o_empty    (w_empty),
    .o_full     (w_full),
    .o_overflow (w_ovf)
  );

  assign bus.pc           = r_pc;
  assign bus.pcPlus       = w_plus;
  assign bus.rasEmpty     = w_empty;
  assign bus.rasOverflow  = w_ovf;
  assign bus.rasUnderflow = r_unf;

endmodule

// File: tb/tb_pc_next_unit.sv
// Directed-vector bench for pc_next_unit with
// queue scoreboard and decoupled monitor.
module tb_pc_next_unit;
  import pc_pkg::*;

  typedef struct {
    logic [31:0] pc;
    logic        e;
    logic        o;
    logic        u;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  exp_t q[$];
  int   n_vec = 0;
  int   n_err = 0;

  pc_next_unit_if #(.WIDTH(32)) bus();

  pc_next_unit #(
    .WIDTH     (32),
    .INC       (4),
    .RAS_DEPTH (4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic step(
    input logic        r,
    input logic        s,
    input logic [2:0]  sel,
    input logic        c,
    input logic [31:0] b,
    input logic [31:0] j,
    input logic [31:0] jr,
    input logic [31:0] epc,
    input logic        ee,
    input logic        eo,
    input logic        eu
  );
    @(negedge clk);
    rst          = r;
    bus.stall    = s;
    bus.pcSel    = sel;
    bus.isCall   = c;
    bus.bResult  = b;
    bus.jTarget  = j;
    bus.jrTarget = jr;
    q.push_back('{epc, ee, eo, eu});
  endtask

  initial begin
    exp_t x;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        x = q.pop_front();
        n_vec++;
        if (bus.pc !== x.pc) begin
          n_err++;
          $display("FAIL v%0d pc got %h want %h",
                   n_vec, bus.pc, x.pc);
        end
        if (bus.pcPlus !== x.pc + 32'd4) begin
          n_err++;
          $display("FAIL v%0d pcPlus got %h want %h",
                   n_vec, bus.pcPlus, x.pc + 32'd4);
        end
        if (bus.rasEmpty !== x.e) begin
          n_err++;
          $display("FAIL v%0d empty got %b want %b",
                   n_vec, bus.rasEmpty, x.e);
        end
        if (bus.rasOverflow !== x.o) begin
          n_err++;
          $display("FAIL v%0d ovf got %b want %b",
                   n_vec, bus.rasOverflow, x.o);
        end
        if (bus.rasUnderflow !== x.u) begin
          n_err++;
          $display("FAIL v%0d unf got %b want %b",
                   n_vec, bus.rasUnderflow, x.u);
        end
      end
    end
  end

  localparam logic [2:0] S = PCSEL_SEQ;
  localparam logic [2:0] B = PCSEL_BRANCH;
  localparam logic [2:0] J = PCSEL_JUMP;
  localparam logic [2:0] R = PCSEL_JREG;
  localparam logic [2:0] T = PCSEL_RET;
  localparam logic [2:0] X = PCSEL_EXC;

  initial begin
    bus.stall    = 1'b0;
    bus.pcSel    = S;
    bus.isCall   = 1'b0;
    bus.bResult  = '0;
    bus.jTarget  = '0;
    bus.jrTarget = '0;
    // reset and sequential
    step(1,0,S,0,0,0,0, 32'd0, 1,0,0);
    step(0,0,S,0,0,0,0, 32'd4, 1,0,0);
    step(0,0,S,0,0,0,0, 32'd8, 1,0,0);
    step(0,0,S,0,0,0,0, 32'd12,1,0,0);
    // reset beats stall
    step(1,1,S,0,0,0,0, 32'd0, 1,0,0);
    // branch / jump / exception
    step(0,0,J,0,0,500,0,  32'd500, 1,0,0);
    step(0,0,B,0,400,0,0,  32'd400, 1,0,0);
    step(0,0,J,0,0,1000,0, 32'd1000,1,0,0);
    step(0,0,X,0,0,0,0, 32'h8000_0180,1,0,0);
    // single call / return
    step(0,0,J,0,0,100,0,  32'd100, 1,0,0);
    step(0,0,J,1,0,2000,0, 32'd2000,0,0,0);
    step(0,0,T,0,0,0,0,    32'd104, 1,0,0);
    // five nested calls into depth-4 RAS
    step(0,0,J,0,0,'h10,0, 32'h10,1,0,0);
    step(0,0,J,1,0,'h20,0, 32'h20,0,0,0);
    step(0,0,J,1,0,'h30,0, 32'h30,0,0,0);
    step(0,0,J,1,0,'h40,0, 32'h40,0,0,0);
    step(0,0,J,1,0,'h50,0, 32'h50,0,0,0);
    step(0,0,J,1,0,'h60,0, 32'h60,0,1,0);
    step(0,0,T,0,0,0,0, 32'h54,0,1,0);
    step(0,0,T,0,0,0,0, 32'h44,0,1,0);
    step(0,0,T,0,0,0,0, 32'h34,0,1,0);
    step(0,0,T,0,0,0,0, 32'h24,1,1,0);
    step(0,0,T,0,0,0,'h999, 32'h999,1,1,1);
    step(0,0,S,0,0,0,0, 32'h99d,1,1,0);
    // reset clears sticky overflow
    step(1,0,S,0,0,0,0, 32'd0,1,0,0);
    // stall freezes pc and RAS
    step(0,0,J,0,0,200,0, 32'd200,1,0,0);
    step(0,1,B,1,400,0,0, 32'd200,1,0,0);
    step(0,1,B,1,400,0,0, 32'd200,1,0,0);
    step(0,1,B,1,400,0,0, 32'd200,1,0,0);
    step(0,0,B,1,400,0,0, 32'd400,0,0,0);
    step(0,0,T,0,0,0,0,   32'd204,1,0,0);
    // stalled RET on empty: no underflow
    step(0,1,T,0,0,0,'h777, 32'd204,1,0,0);
    step(0,0,S,0,0,0,0,     32'd208,1,0,0);
    // wrap and invalid selects
    step(0,0,J,0,0,'hFFFF_FFFC,0,
         32'hFFFF_FFFC,1,0,0);
    step(0,0,S,0,0,0,0,    32'd0,1,0,0);
    step(0,0,3'd7,0,0,0,0, 32'd4,1,0,0);
    step(0,0,3'd6,1,0,0,0, 32'd8,1,0,0);
    step(0,0,T,0,0,0,'h300, 32'h300,1,0,1);
    // JREG call, EXC preserves RAS
    step(0,0,R,1,0,0,'h123, 32'h123,0,0,0);
    step(0,0,T,0,0,0,0,     32'h304,1,0,0);
    step(0,0,J,1,0,'h40,0,  32'h40,0,0,0);
    step(0,0,X,1,0,0,0, 32'h8000_0180,0,0,0);
    step(0,0,T,0,0,0,0,     32'h308,1,0,0);
    step(0,0,S,0,0,0,0,     32'h30c,1,0,0);
    for (int k = 0; k < 10 && q.size() > 0; k++)
      @(negedge clk);
    if (q.size() > 0) begin
      n_err++;
      $display("FAIL drain left %0d want 0",
               q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/pc_next_unit.md
Name: pc_next_unit

Overview:
- Parametrised successor to the two-input PC source mux.
- Holds the architectural PC register and selects next PC from six sources: sequential, branch, jump, jump-register, return, exception.
- Includes a small circular return-address stack (RAS) for call/return prediction.
- Sits between the control unit (pcSel, isCall, stall) and the instruction-memory address port.

Parameters:
- WIDTH, 32, PC/address width in bits
- INC, 4, sequential increment added to PC
- RESET_VECTOR, 32'h0000_0000, PC value loaded on reset
- EXC_VECTOR, 32'h8000_0180, PC value loaded on exception select
- RAS_DEPTH, 4, return-address stack entries (power of two, >=2)

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous active-high reset
- stall  in  1  freeze PC and RAS this cycle
- pcSel  in  3  next-PC source: 0 SEQ, 1 BRANCH, 2 JUMP, 3 JREG, 4 RET, 5 EXC, 6/7 treated as SEQ
- isCall  in  1  push current pc+INC onto RAS (valid with BRANCH/JUMP/JREG only)
- bResult  in  WIDTH  branch target
- jTarget  in  WIDTH  jump target
- jrTarget  in  WIDTH  register-indirect target; also fallback for RET on empty RAS
- pc  out  WIDTH  current PC (registered)
- pcPlus  out  WIDTH  pc+INC (combinational from pc)
- rasEmpty  out  1  RAS holds zero valid entries
- rasOverflow  out  1  sticky: a push overwrote a valid entry
- rasUnderflow  out  1  one-cycle pulse (registered): RET taken with RAS empty

Behaviour:
- Reset (rst=1 at clk edge, overrides everything, including stall): pc=RESET_VECTOR, RAS count=0, top pointer=0, rasEmpty=1, rasOverflow=0, rasUnderflow=0.
- Arithmetic: pcPlus = pc+INC, modulo 2^WIDTH. Wrap from all-ones region to low addresses is legal and silent.
- Latency: a selection presented in cycle N appears on pc after the edge ending cycle N (one cycle).
- stall=1: pc, RAS contents, count and flags hold. rasUnderflow is forced 0. All other inputs are ignored.
- Next-PC per pcSel when not stalled:
  - SEQ -> pcPlus
  - BRANCH -> bResult
  - JUMP -> jTarget
  - JREG -> jrTarget
  - RET -> RAS top if count>0, else jrTarget with rasUnderflow=1 next cycle
  - EXC -> EXC_VECTOR
- Push (isCall=1, pcSel in {BRANCH, JUMP, JREG}, no stall): write pcPlus at top+1, increment top modulo RAS_DEPTH.
  - If count<RAS_DEPTH, count increments.
  - If count==RAS_DEPTH, the oldest entry is overwritten, count stays, and rasOverflow is set (sticky until rst).
- Pop (pcSel=RET, count>0, no stall): next pc=entry[top], decrement top modulo RAS_DEPTH and count.
- isCall with SEQ, RET, EXC or invalid select is ignored (no push).
- EXC: no push or pop; RAS is preserved.
- rasEmpty = (count==0), combinational from registered count.
- The RAS is a register array; no memory inference is required.

Decomposition:
- Shared package pc_pkg:
  - pcSel encodings as localparams: PCSEL_SEQ … PCSEL_EXC
  - default vectors RESET_VECTOR and EXC_VECTOR
- One natural sub-module: ras_stack (parametrised WIDTH/RAS_DEPTH).
  - Interface: push, pop, wdata, top_data, empty, full, overflow.
  - pc_next_unit instantiates it and contains the PC register and source mux.

Test Plan:
- Reset then 3 cycles of SEQ (INC=4) -> pc = 0, 4, 8, 12. Assert rst mid-run at pc=12 -> pc=0 next edge, rasEmpty=1.
- pc=32'd500, BRANCH with bResult=400 -> pc=400. Then JUMP with jTarget=1000 -> pc=1000. Then EXC -> pc=32'h8000_0180.
- Call/return: at pc=100, JUMP with isCall=1 and jTarget=2000 -> pc=2000, rasEmpty=0. Then RET -> pc=104, rasEmpty=1.
- Overflow: 5 nested calls from pcs 0x10, 0x20, 0x30, 0x40, 0x50 (DEPTH=4) -> rasOverflow=1. Then 4 RETs -> 0x54, 0x44, 0x34, 0x24. A 5th RET with jrTarget=0x999 -> pc=0x999, rasUnderflow pulses 1 for one cycle.
- Stall: pc=200, stall=1 with BRANCH, bResult=400, isCall=1 for 3 cycles -> pc stays 200, RAS count unchanged. Release stall -> pc=400, pushed entry=204.
- Wrap and invalid select: pc=32'hFFFF_FFFC, SEQ -> pc=0. pcSel=7 -> behaves as SEQ. pcSel=6 with isCall=1 -> no push.
